// File: rtl/sprite_layer_mux.sv
// sprite_layer_mux
//   Two-stage pixel compositor for NUM_LAYERS sprite layers over a background.
//   Stage 1 registers the (mode/blink masked) hit flags, layer colours,
//   background colour and video_on; stage 2 registers the selected pixel.
//   Turn mode lets only the current-turn layer win. Priority mode lets the
//   lowest-index hit win.
//
//   Optional feature: define SPRITE_MUX_BLINK_EN to compile in frame-based
//   blinking. The current-turn layer is hidden for BLINK_FRAMES frames out of
//   every 2*BLINK_FRAMES.
//
// Ports
//   clk           pixel clock
//   rst           synchronous active-high reset
//   layer_visible per-layer hit flag, bit i = layer i
//   layer_rgb     packed layer colours, layer i at [i*COLOR_W +: COLOR_W]
//   bg_rgb        background colour
//   video_on_in   active-area flag aligned with the layer inputs
//   frame_start   one-cycle pulse per frame (used only by the blink feature)
//   mode          0 = turn mode, 1 = priority mode
//   turn_advance  pulse: advance the turn to the next layer
//   turn_clear    pulse: force the turn to 0 (wins over turn_advance)
//   rgb_out       composited colour (2-cycle latency)
//   visible_out   a layer won this pixel
//   layer_id_out  index of the winning layer (0 if none)
//   video_on_out  video_on_in delayed to match rgb_out
//   turn_out      current turn index
module sprite_layer_mux #(
    parameter int NUM_LAYERS   = 2,
    parameter int COLOR_W      = 24,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_LAYERS-1:0]         layer_visible,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    input  logic [COLOR_W-1:0]            bg_rgb,
    input  logic                          video_on_in,
    input  logic                          frame_start,
    input  logic                          mode,
    input  logic                          turn_advance,
    input  logic                          turn_clear,
    output logic [COLOR_W-1:0]            rgb_out,
    output logic                          visible_out,
    output logic [2:0]                    layer_id_out,
    output logic                          video_on_out,
    output logic [2:0]                    turn_out
);

    logic [2:0]                    turn;
    logic [NUM_LAYERS-1:0]         turn_sel;
    logic [NUM_LAYERS-1:0]         mode_mask;
    logic [NUM_LAYERS-1:0]         vis_masked;

    logic [NUM_LAYERS-1:0]         vis_s1;
    logic [NUM_LAYERS*COLOR_W-1:0] rgb_s1;
    logic [COLOR_W-1:0]            bg_s1;
    logic                          von_s1;

    logic                          hit;
    logic [2:0]                    win_id;
    logic [COLOR_W-1:0]            win_rgb;

    // Turn counter; clear has priority over advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            turn <= '0;
        end else if (turn_clear) begin
            turn <= '0;
        end else if (turn_advance) begin
            if (turn == 3'(NUM_LAYERS - 1))
                turn <= '0;
            else
                turn <= turn + 3'd1;
        end
    end

    assign turn_out = turn;

    // One-hot decode of the current turn.
    always_comb begin
        turn_sel = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++)
            turn_sel[i] = (turn == 3'(i));
    end

    assign mode_mask = mode ? '1 : turn_sel;

`ifdef SPRITE_MUX_BLINK_EN
    logic [7:0] frame_cnt;
    logic       blink_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // During the off phase the current-turn layer is removed from the
    // candidate set, so in priority mode a lower-priority layer may win.
    assign vis_masked = layer_visible & mode_mask & ~(blink_phase ? turn_sel : '0);
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
    assign vis_masked = layer_visible & mode_mask;
`endif

    // Stage 1: capture masked hits and colours.
    always_ff @(posedge clk) begin
        if (rst) begin
            vis_s1 <= '0;
            rgb_s1 <= '0;
            bg_s1  <= '0;
            von_s1 <= 1'b0;
        end else begin
            vis_s1 <= vis_masked;
            rgb_s1 <= layer_rgb;
            bg_s1  <= bg_rgb;
            von_s1 <= video_on_in;
        end
    end

    // Lowest-index surviving hit wins. In turn mode at most one bit survives
    // the mask, so the same encoder serves both modes.
    always_comb begin
        hit     = 1'b0;
        win_id  = '0;
        win_rgb = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (!hit && vis_s1[i]) begin
                hit     = 1'b1;
                win_id  = 3'(i);
                win_rgb = rgb_s1[i*COLOR_W +: COLOR_W];
            end
        end
    end

    // Stage 2: registered selection result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out      <= '0;
            visible_out  <= 1'b0;
            layer_id_out <= '0;
            video_on_out <= 1'b0;
        end else begin
            video_on_out <= von_s1;
            if (!von_s1) begin
                rgb_out      <= '0;
                visible_out  <= 1'b0;
                layer_id_out <= '0;
            end else if (hit) begin
                rgb_out      <= win_rgb;
                visible_out  <= 1'b1;
                layer_id_out <= win_id;
            end else begin
                rgb_out      <= bg_s1;
                visible_out  <= 1'b0;
                layer_id_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_layer_mux.sv
module tb_sprite_layer_mux;

    localparam int N  = 3;
    localparam int CW = 24;
    localparam int BF = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      layer_visible = '0;
    logic [N*CW-1:0]   layer_rgb = '0;
    logic [CW-1:0]     bg_rgb = '0;
    logic              video_on_in = 1'b0;
    logic              frame_start = 1'b0;
    logic              mode = 1'b0;
    logic              turn_advance = 1'b0;
    logic              turn_clear = 1'b0;
    logic [CW-1:0]     rgb_out;
    logic              visible_out;
    logic [2:0]        layer_id_out;
    logic              video_on_out;
    logic [2:0]        turn_out;

    sprite_layer_mux #(
        .NUM_LAYERS   (N),
        .COLOR_W      (CW),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .layer_visible (layer_visible),
        .layer_rgb     (layer_rgb),
        .bg_rgb        (bg_rgb),
        .video_on_in   (video_on_in),
        .frame_start   (frame_start),
        .mode          (mode),
        .turn_advance  (turn_advance),
        .turn_clear    (turn_clear),
        .rgb_out       (rgb_out),
        .visible_out   (visible_out),
        .layer_id_out  (layer_id_out),
        .video_on_out  (video_on_out),
        .turn_out      (turn_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [CW-1:0] rgb;
        logic        vis;
        logic [2:0]  id;
        logic        von;
    } px_t;

    typedef struct {
        int         due;
        logic [2:0] turn;
    } turn_t;

    px_t   pq[$];
    turn_t tq[$];

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    // Reference state: current turn and number of frame pulses since reset.
    int m_turn = 0;
    int m_frames = 0;

    function automatic bit blink_off();
`ifdef SPRITE_MUX_BLINK_EN
        return ((m_frames / BF) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    // Expected pixel given the reference state at the moment it enters.
    function automatic px_t model_px(input logic [N-1:0] vis, input logic [N*CW-1:0] rgbs,
                                     input logic [CW-1:0] bg, input logic von, input logic md);
        px_t p;
        logic [CW-1:0] c;
        p.due = 0; p.rgb = '0; p.vis = 1'b0; p.id = '0; p.von = von;
        if (!von) return p;
        p.rgb = bg;
        for (int i = 0; i < N; i++) begin
            bit allowed;
            allowed = vis[i] && (md || i == m_turn) && !(blink_off() && i == m_turn);
            if (allowed) begin
                c = rgbs[i*CW +: CW];
                p.rgb = c;
                p.vis = 1'b1;
                p.id  = 3'(i);
                return p;
            end
        end
        return p;
    endfunction

    // Applies one cycle of inputs, records expectations, advances the model.
    task automatic drive(input logic r, input logic [N-1:0] vis, input logic [N*CW-1:0] rgbs,
                         input logic [CW-1:0] bg, input logic von, input logic fs,
                         input logic md, input logic adv, input logic clr);
        px_t   p;
        turn_t t;
        rst = r; layer_visible = vis; layer_rgb = rgbs; bg_rgb = bg;
        video_on_in = von; frame_start = fs; mode = md; turn_advance = adv; turn_clear = clr;
        if (r) begin
            // Everything in flight is discarded; outputs read zero until the
            // first pixel after reset emerges.
            pq.delete();
            p.rgb = '0; p.vis = 1'b0; p.id = '0; p.von = 1'b0;
            p.due = cyc + 1; pq.push_back(p);
            p.due = cyc + 2; pq.push_back(p);
            m_turn = 0;
            m_frames = 0;
        end else begin
            p = model_px(vis, rgbs, bg, von, md);
            p.due = cyc + 2;
            pq.push_back(p);
            if (clr) m_turn = 0;
            else if (adv) m_turn = (m_turn + 1) % N;
            if (fs) m_frames++;
        end
        t.due = cyc + 1;
        t.turn = 3'(m_turn);
        tq.push_back(t);
        @(negedge clk);
    endtask

    function automatic logic [N*CW-1:0] rgb3(input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                                             input logic [CW-1:0] c2);
        return {c2, c1, c0};
    endfunction

    // Monitor: compares every output whose due cycle has arrived.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (pq.size() > 0 && pq[0].due <= cyc) begin
                px_t p;
                p = pq.pop_front();
                n_vec++;
                if (p.due != cyc || rgb_out !== p.rgb || visible_out !== p.vis ||
                    layer_id_out !== p.id || video_on_out !== p.von) begin
                    n_bad++;
                    $display("FAIL pixel cyc=%0d due=%0d got rgb=%06h vis=%b id=%0d von=%b exp rgb=%06h vis=%b id=%0d von=%b",
                             cyc, p.due, rgb_out, visible_out, layer_id_out, video_on_out,
                             p.rgb, p.vis, p.id, p.von);
                end
            end
            while (tq.size() > 0 && tq[0].due <= cyc) begin
                turn_t t;
                t = tq.pop_front();
                n_vec++;
                if (t.due != cyc || turn_out !== t.turn) begin
                    n_bad++;
                    $display("FAIL turn cyc=%0d got=%0d exp=%0d", cyc, turn_out, t.turn);
                end
            end
        end
    end

    initial begin
        logic [N*CW-1:0] rr;
        int wait_cyc;
        @(negedge clk);
        // Reset state.
        repeat (3) drive(1'b1, '1, '1, '1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Priority mode, two layers hit: layer 0 wins.
        rr = rgb3(24'hFF0000, 24'h0000FF, 24'h00FF00);
        drive(1'b0, 3'b011, rr, 24'h202020, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 3'b110, rr, 24'h202020, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        // Turn mode, turn 0, only layer 1 hits: background. Then advance.
        drive(1'b0, 3'b010, rr, 24'h202020, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 3'b010, rr, 24'h202020, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Advance wraps 1 -> 2 -> 0.
        drive(1'b0, 3'b111, rr, 24'h202020, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 3'b111, rr, 24'h202020, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 3'b111, rr, 24'h202020, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        // Clear beats advance at turn 1.
        drive(1'b0, 3'b111, rr, 24'h202020, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        // Video off with all layers hit.
        drive(1'b0, 3'b111, rr, 24'h202020, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Reach turn 2 then reset mid-stream.
        drive(1'b0, 3'b100, rr, 24'h202020, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 3'b100, rr, 24'h202020, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 3'b100, rr, 24'h202020, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'b111, rr, 24'h202020, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        // Turn mode with frame pulses (blink visible when compiled in).
        repeat (8) drive(1'b0, 3'b001, rr, 24'h202020, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            logic [N*CW-1:0] rnd;
            for (int i = 0; i < N; i++) rnd[i*CW +: CW] = CW'($urandom);
            drive(($urandom_range(0, 59) == 0), N'($urandom), rnd, CW'($urandom),
                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0));
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        wait_cyc = 0;
        while ((pq.size() > 0 || tq.size() > 0) && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (pq.size() > 0 || tq.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain pending=%0d exp=0", pq.size() + tq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
